// File: rtl/keypad_matrix_scanner.sv
// Row/column push-button matrix scanner: drives one column low at a time, debounces
// a single key and reports it through a valid/ack handshake with sticky overrun.
module keypad_matrix_scanner #(
  parameter int COLS          = 4,
  parameter int ROWS          = 4,
  parameter int SETTLE_TICKS  = 2,
  parameter int DEBOUNCE_SMPL = 3,
  parameter int CODE_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_tick,
  input  logic [ROWS-1:0]   row_sense,
  output logic [COLS-1:0]   col_drive,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ack,
  output logic              key_held,
  output logic              overrun
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TICK_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SMPL + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t            state;
  logic [ROWS-1:0]   row_p0;
  logic [ROWS-1:0]   row_p1;
  logic [COL_W-1:0]  col;
  logic [TICK_W-1:0] tick_cnt;
  logic [CNT_W-1:0]  match_cnt;
  logic [ROW_W-1:0]  cand;

  logic              sample;
  logic              rows_idle;
  logic [ROW_W-1:0]  low_idx;
  logic              accept;
  logic [COL_W-1:0]  col_next;

  function automatic logic [ROW_W-1:0] lowest_low(input logic [ROWS-1:0] rows);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) idx = ROW_W'(r);
    end
    return idx;
  endfunction

  function automatic logic [COLS-1:0] col_mask(input logic [COL_W-1:0] c);
    logic [COLS-1:0] m;
    m    = '1;
    m[c] = 1'b0;
    return m;
  endfunction

  always_comb begin
    sample    = scan_tick && (tick_cnt == TICK_W'(SETTLE_TICKS - 1));
    rows_idle = &row_p1;
    low_idx   = lowest_low(row_p1);
    col_next  = (col == COL_W'(COLS - 1)) ? '0 : col + COL_W'(1);
    accept    = sample && (state == DEBOUNCE) && !rows_idle && (low_idx == cand) &&
                (match_cnt == CNT_W'(DEBOUNCE_SMPL - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_p0    <= '1;
      row_p1    <= '1;
      state     <= SCAN;
      col       <= '0;
      col_drive <= col_mask('0);
      tick_cnt  <= '0;
      match_cnt <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchronizer on the raw row lines
      row_p0 <= row_sense;
      row_p1 <= row_p0;

      // handshake runs every clock; an accept in the same cycle as ack wins
      if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      if (accept) begin
        if (!key_valid || key_ack) begin
          key_code  <= CODE_W'(int'(cand) * COLS + int'(col));
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (scan_tick) tick_cnt <= sample ? '0 : tick_cnt + TICK_W'(1);

      if (sample) begin
        case (state)
          SCAN: begin
            if (rows_idle) begin
              col       <= col_next;
              col_drive <= col_mask(col_next);
            end else begin
              cand      <= low_idx;
              match_cnt <= CNT_W'(1);
              state     <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!rows_idle && low_idx == cand) begin
              if (accept) begin
                match_cnt <= '0;
                key_held  <= 1'b1;
                state     <= HELD;
              end else begin
                match_cnt <= match_cnt + CNT_W'(1);
              end
            end else begin
              col       <= col_next;
              col_drive <= col_mask(col_next);
              state     <= SCAN;
            end
          end
          HELD: begin
            // release must be seen on consecutive samples; any press restarts it
            if (row_p1[cand]) begin
              if (match_cnt == CNT_W'(DEBOUNCE_SMPL - 1)) begin
                match_cnt <= '0;
                key_held  <= 1'b0;
                col       <= col_next;
                col_drive <= col_mask(col_next);
                state     <= SCAN;
              end else begin
                match_cnt <= match_cnt + CNT_W'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a physical key-matrix model feeds row_sense from
// col_drive, expected key codes are queued on press and popped when key_valid rises.
module tb_keypad_matrix_scanner;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int CODE_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              scan_tick = 1'b0;
  logic [ROWS-1:0]   row_sense;
  logic [COLS-1:0]   col_drive;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ack = 1'b0;
  logic              key_held;
  logic              overrun;

  logic [ROWS*COLS-1:0] keys = '0;
  int                   tick_period = 1;
  int                   tick_count = 0;
  int                   n_checks = 0;
  int                   n_fail = 0;
  int                   exp_q[$];

  keypad_matrix_scanner #(.COLS(COLS), .ROWS(ROWS), .SETTLE_TICKS(2), .DEBOUNCE_SMPL(3),
                          .CODE_W(CODE_W)) dut (
    .clock(clock), .reset(reset), .scan_tick(scan_tick), .row_sense(row_sense),
    .col_drive(col_drive), .key_valid(key_valid), .key_code(key_code),
    .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // physical matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_sense = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col_drive[c] && keys[r*COLS+c]) row_sense[r] = 1'b0;
  end

  initial begin
    forever begin
      @(negedge clock);
      tick_count++;
      scan_tick = ((tick_count % tick_period) == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int period);
    tick_period = period;
    keys = '0;
    key_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clock);
    key_ack = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (key_valid !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    ok = (key_valid === 1'b1);
  endtask

  task automatic wait_held(input logic lvl, output bit ok);
    int n = 0;
    while (key_held !== lvl && n < 400) begin @(negedge clock); n++; end
    ok = (key_held === lvl);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (col_drive !== 4'b1110) begin n_fail++; $display("FAIL reset_col_drive got %b want 1110", col_drive); end
    n_checks++;
    if ({key_valid, key_held, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got v=%b h=%b o=%b want 0 0 0", key_valid, key_held, overrun);
    end
    n_checks++;
    if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code got %0d want 0", key_code); end
  endtask

  task automatic test_scan_cycle();
    logic [COLS-1:0] exp_col;
    int bad_col = 0;
    int bad_vld = 0;
    do_reset(1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      exp_col = '1;
      exp_col[(k/2) % COLS] = 1'b0;
      if (col_drive !== exp_col) begin
        bad_col++;
        $display("FAIL scan_col cycle %0d got %b want %b", k, col_drive, exp_col);
      end
      if (key_valid !== 1'b0) bad_vld++;
    end
    n_checks++;
    if (bad_col != 0) begin n_fail++; $display("FAIL scan_sequence got %0d bad cycles want 0", bad_col); end
    n_checks++;
    if (bad_vld != 0) begin n_fail++; $display("FAIL scan_no_valid got %0d valid cycles want 0", bad_vld); end
  endtask

  task automatic test_single_key();
    bit ok;
    int exp;
    int n;
    do_reset(4);
    keys[9] = 1'b1;
    exp_q.push_back(9);
    wait_valid(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_valid got timeout want key_valid=1"); end
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_queue got empty want entry"); end
    else begin
      exp = exp_q.pop_front();
      if (key_code !== CODE_W'(exp)) begin n_fail++; $display("FAIL single_code got %0d want %0d", key_code, exp); end
    end
    n_checks++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL single_held got %b want 1", key_held); end
    ack_pulse();
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack got %b want 0", key_valid); end
    keys[9] = 1'b0;
    n = 0;
    while (key_held === 1'b1 && n < 100) begin @(negedge clock); n++; end
    n_checks++;
    if (n < 16 || n > 28) begin n_fail++; $display("FAIL release_window got %0d clocks want 16..28", n); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun got %b want 0", overrun); end
  endtask

  task automatic test_bounce();
    int n = 0;
    int vld = 0;
    do_reset(4);
    while (col_drive !== 4'b0111 && n < 100) begin @(negedge clock); n++; end
    keys[3] = 1'b1;
    repeat (10) @(negedge clock);
    n_checks++;
    if (col_drive !== 4'b0111) begin n_fail++; $display("FAIL bounce_frozen got %b want 0111", col_drive); end
    keys[3] = 1'b0;
    n = 0;
    while (col_drive === 4'b0111 && n < 40) begin
      @(negedge clock); n++;
      if (key_valid !== 1'b0) vld++;
    end
    n_checks++;
    if (col_drive !== 4'b1110) begin n_fail++; $display("FAIL bounce_resume got %b want 1110", col_drive); end
    repeat (80) begin @(negedge clock); if (key_valid !== 1'b0) vld++; end
    n_checks++;
    if (vld != 0) begin n_fail++; $display("FAIL bounce_no_valid got %0d valid cycles want 0", vld); end
  endtask

  task automatic test_overrun();
    bit ok;
    int exp;
    do_reset(4);
    keys[5] = 1'b1;
    exp_q.push_back(5);
    wait_valid(ok);
    n_checks++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL overrun_first got timeout want key_valid=1"); end
    else begin
      exp = exp_q.pop_front();
      if (key_code !== CODE_W'(exp)) begin n_fail++; $display("FAIL overrun_first_code got %0d want %0d", key_code, exp); end
    end
    keys[5] = 1'b0;
    wait_held(1'b0, ok);
    keys[14] = 1'b1;
    wait_held(1'b1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL overrun_second got timeout want key_held=1"); end
    n_checks++;
    if (key_code !== 4'd5) begin n_fail++; $display("FAIL overrun_code_kept got %0d want 5", key_code); end
    n_checks++;
    if (overrun !== 1'b1 || key_valid !== 1'b1) begin
      n_fail++; $display("FAIL overrun_flag got o=%b v=%b want 1 1", overrun, key_valid);
    end
    keys[14] = 1'b0;
    ack_pulse();
    n_checks++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_ack got v=%b o=%b want 0 0", key_valid, overrun);
    end
    wait_held(1'b0, ok);
  endtask

  task automatic test_lowest_row();
    bit ok;
    int exp;
    do_reset(4);
    ack_pulse();
    n_checks++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack got v=%b o=%b want 0 0", key_valid, overrun);
    end
    keys[4] = 1'b1;
    keys[12] = 1'b1;
    exp_q.push_back(4);
    wait_valid(ok);
    n_checks++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL lowest_valid got timeout want key_valid=1"); end
    else begin
      exp = exp_q.pop_front();
      if (key_code !== CODE_W'(exp)) begin n_fail++; $display("FAIL lowest_code got %0d want %0d", key_code, exp); end
    end
    ack_pulse();
    keys = '0;
    wait_held(1'b0, ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp;
    int seq[2] = '{15, 6};
    do_reset(4);
    foreach (seq[i]) begin
      keys[seq[i]] = 1'b1;
      exp_q.push_back(seq[i]);
      wait_valid(ok);
      n_checks++;
      if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_valid[%0d] got timeout want key_valid=1", i); end
      else begin
        exp = exp_q.pop_front();
        if (key_code !== CODE_W'(exp)) begin n_fail++; $display("FAIL b2b_code[%0d] got %0d want %0d", i, key_code, exp); end
      end
      ack_pulse();
      keys[seq[i]] = 1'b0;
      wait_held(1'b0, ok);
      n_checks++;
      if (!ok || key_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_release[%0d] got h=%b v=%b want 0 0", i, key_held, key_valid); end
    end
  endtask

  task automatic test_reset_in_held();
    bit ok;
    int exp;
    do_reset(4);
    keys[11] = 1'b1;
    exp_q.push_back(11);
    wait_valid(ok);
    n_checks++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL rsth_valid got timeout want key_valid=1"); end
    else begin
      exp = exp_q.pop_front();
      if (key_code !== CODE_W'(exp)) begin n_fail++; $display("FAIL rsth_code got %0d want %0d", key_code, exp); end
    end
    keys[11] = 1'b0;
    wait_held(1'b0, ok);
    keys[6] = 1'b1;
    wait_held(1'b1, ok);
    n_checks++;
    if (!ok || overrun !== 1'b1) begin n_fail++; $display("FAIL rsth_setup got h=%b o=%b want 1 1", key_held, overrun); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (col_drive !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rsth_clear got col=%b v=%b h=%b o=%b want 1110 0 0 0", col_drive, key_valid, key_held, overrun);
    end
    n_checks++;
    if (key_code !== 4'd0) begin n_fail++; $display("FAIL rsth_code_clear got %0d want 0", key_code); end
    keys = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_cycle();
    test_single_key();
    test_bounce();
    test_overrun();
    test_lowest_row();
    test_back_to_back();
    test_reset_in_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
